// File: rtl/trivium_pkg.sv
// rtl/trivium_pkg.sv - shared constants and FSM encoding for the Trivium word adapter
package trivium_pkg;

  localparam int KEY_W      = 80;
  localparam int WORD_W     = 32;
  localparam int PRE_CYCLES = 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAKE      = 3'd1;
  localparam logic [2:0] S_SEND_IV   = 3'd2;
  localparam logic [2:0] S_SEND_KEY  = 3'd3;
  localparam logic [2:0] S_WAIT_BUSY = 3'd4;
  localparam logic [2:0] S_READY     = 3'd5;
  localparam logic [2:0] S_PRE       = 3'd6;
  localparam logic [2:0] S_SHIFT     = 3'd7;

endpackage

// File: rtl/trivium_piso.sv
// rtl/trivium_piso.sv - parallel-load, LSB-first shift register with serial-in at the MSB
module trivium_piso
  import trivium_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] pdata_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o,
  output logic         sout_o
);

  logic [W-1:0] sr_q;

  // Load wins over shift; a shift moves right and pulls sin_i into the MSB.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= pdata_i;
    end else if (shift_i) begin
      sr_q <= {sin_i, sr_q[W-1:1]};
    end
  end

  assign q_o    = sr_q;
  assign sout_o = sr_q[0];

endmodule

// File: rtl/trivium_word_if.sv
// rtl/trivium_word_if.sv - word-level host adapter driving the bit-serial Trivium core
module trivium_word_if #(
  parameter int KEY_W        = trivium_pkg::KEY_W,
  parameter int WORD_W       = trivium_pkg::WORD_W,
  parameter int INIT_TIMEOUT = 2048
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic [KEY_W-1:0]  iv_i,
  input  logic              load_i,
  output logic              load_ready_o,
  input  logic              end_i,
  input  logic [WORD_W-1:0] din_i,
  input  logic              din_valid_i,
  output logic              din_ready_o,
  output logic [WORD_W-1:0] dout_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic              keyed_o,
  output logic              err_o,
  output logic              core_dat_o,
  output logic              core_init_o,
  output logic              core_end_o,
  input  logic              core_dat_i,
  input  logic              core_busy_i
);
  import trivium_pkg::*;

  localparam int               TMO_W     = $clog2(INIT_TIMEOUT + 1);
  localparam logic [6:0]       KV_LAST   = 7'(KEY_W - 1);
  localparam logic [4:0]       WORD_LAST = 5'(WORD_W - 1);
  localparam logic [4:0]       PRE_LAST  = 5'(PRE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(INIT_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [4:0]        bcnt_q, bcnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              dv_q, dv_d;
  logic              err_q, err_d;

  logic              load_acc, din_acc;
  logic              kv_load, kv_shift, kv_sout;
  logic [KEY_W-1:0]  kv_pdata, kv_unused;
  logic              wd_load, wd_shift, wd_sout;
  logic [WORD_W-1:0] wd_q;

  assign load_ready_o = (state_q == S_IDLE) || (state_q == S_READY);
  assign load_acc     = load_i && load_ready_o;
  // A word is only taken when load and end, which outrank it, are both absent.
  assign din_ready_o  = (state_q == S_READY) && !load_i && !end_i && (!dv_q || dout_ready_i);
  assign din_acc      = din_valid_i && din_ready_o;

  assign keyed_o      = (state_q == S_READY) || (state_q == S_PRE) || (state_q == S_SHIFT);
  assign err_o        = err_q;
  assign dout_valid_o = dv_q;
  assign dout_o       = dv_q ? wd_q : '0;
  assign core_end_o   = (state_q == S_READY) && end_i && !load_i;
  assign core_init_o  = (state_q == S_WAKE) || (state_q == S_SEND_IV) || (state_q == S_SEND_KEY) ||
                        (state_q == S_PRE) || (state_q == S_SHIFT);

  // The same shifter streams the IV and then the key, reloaded at the IV/key boundary.
  assign kv_pdata = load_acc ? iv_i : key_q;
  assign kv_shift = (state_q == S_SEND_IV) || (state_q == S_SEND_KEY);
  assign wd_shift = (state_q == S_SHIFT);

  // Select which shifter feeds the core's serial input; idle phases drive 0.
  always_comb begin
    core_dat_o = 1'b0;
    case (state_q)
      S_SEND_IV, S_SEND_KEY: core_dat_o = kv_sout;
      S_PRE, S_SHIFT:        core_dat_o = wd_sout;
      default:               core_dat_o = 1'b0;
    endcase
  end

  // Next-state, counters and shifter load strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    tmo_d   = tmo_q;
    key_d   = key_q;
    dv_d    = dv_q;
    err_d   = err_q;
    kv_load = 1'b0;
    wd_load = 1'b0;
    if (dv_q && dout_ready_i) dv_d = 1'b0;
    if (load_acc) begin
      key_d   = key_i;
      err_d   = 1'b0;
      kv_load = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (load_acc) begin
          state_d = S_WAKE;
          cnt_d   = '0;
        end
      end
      S_WAKE: begin
        state_d = S_SEND_IV;
        cnt_d   = '0;
      end
      S_SEND_IV: begin
        if (cnt_q == KV_LAST) begin
          state_d = S_SEND_KEY;
          cnt_d   = '0;
          kv_load = 1'b1;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_SEND_KEY: begin
        if (cnt_q == KV_LAST) begin
          state_d = S_WAIT_BUSY;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_WAIT_BUSY: begin
        if (!core_busy_i) begin
          state_d = S_READY;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_READY: begin
        if (load_acc) begin
          state_d = S_WAKE;
          cnt_d   = '0;
        end else if (end_i) begin
          state_d = S_IDLE;
        end else if (din_acc) begin
          state_d = S_PRE;
          bcnt_d  = '0;
          wd_load = 1'b1;
        end
      end
      S_PRE: begin
        if (bcnt_q == PRE_LAST) begin
          state_d = S_SHIFT;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 5'd1;
        end
      end
      S_SHIFT: begin
        if (bcnt_q == WORD_LAST) begin
          state_d = S_READY;
          bcnt_d  = '0;
          dv_d    = 1'b1;
        end else begin
          bcnt_d = bcnt_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      tmo_q   <= '0;
      key_q   <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      tmo_q   <= tmo_d;
      key_q   <= key_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  trivium_piso #(.W(KEY_W)) u_kv_sr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (kv_load),
    .pdata_i (kv_pdata),
    .shift_i (kv_shift),
    .sin_i   (1'b0),
    .q_o     (kv_unused),
    .sout_o  (kv_sout)
  );

  // Plaintext goes out of the LSB while cipher bits enter at the MSB.
  trivium_piso #(.W(WORD_W)) u_word_sr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (wd_load),
    .pdata_i (din_i),
    .shift_i (wd_shift),
    .sin_i   (core_dat_i),
    .q_o     (wd_q),
    .sout_o  (wd_sout)
  );

endmodule

// File: tb/tb_trivium_word_if.sv
// tb/tb_trivium_word_if.sv - scoreboard bench for trivium_word_if
module tb_trivium_word_if;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [79:0] key_i, iv_i;
  logic        load_i, end_i;
  logic [31:0] din_i;
  logic        din_valid_i, dout_ready_i;
  logic        core_busy_i;
  wire         load_ready_o, din_ready_o, dout_valid_o, keyed_o, err_o;
  wire  [31:0] dout_o;
  wire         core_dat_o, core_init_o, core_end_o, core_dat_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int run = 0;
  logic vprev = 1'b0;

  bit          ser_q[$];
  int          run_q[$];
  logic [31:0] dexp_q[$];
  int          dcyc_q[$];

  trivium_word_if dut (
    .clk_i(clk_i), .rst_i(rst_i), .key_i(key_i), .iv_i(iv_i),
    .load_i(load_i), .load_ready_o(load_ready_o), .end_i(end_i),
    .din_i(din_i), .din_valid_i(din_valid_i), .din_ready_o(din_ready_o),
    .dout_o(dout_o), .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
    .keyed_o(keyed_o), .err_o(err_o),
    .core_dat_o(core_dat_o), .core_init_o(core_init_o), .core_end_o(core_end_o),
    .core_dat_i(core_dat_i), .core_busy_i(core_busy_i)
  );

  // Core stand-in: keystream of all ones, so each cipher bit is the inverted plaintext bit.
  assign core_dat_i = core_dat_o ^ 1'b1;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Serial monitor: every init-high cycle must match the next expected core_dat_o bit.
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      run = 0;
    end else if (core_init_o) begin
      chk("serial_expected", ser_q.size() != 0, 1);
      if (ser_q.size() != 0) chk("serial_bit", core_dat_o, ser_q.pop_front());
      run++;
    end else if (run > 0) begin
      chk("init_run_expected", run_q.size() != 0, 1);
      if (run_q.size() != 0) chk("init_run_len", run, run_q.pop_front());
      run = 0;
    end
  end

  // Output monitor: each new dout_valid_o must match the next queued word and its latency.
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      vprev = 1'b0;
    end else begin
      if (dout_valid_o && !vprev) begin
        chk("dout_expected", dexp_q.size() != 0, 1);
        if (dexp_q.size() != 0) begin
          chk("dout_data", dout_o, dexp_q.pop_front());
          chk("dout_latency", cyc, dcyc_q.pop_front());
        end
      end
      vprev = dout_valid_o;
    end
  end

  task automatic push_load(input logic [79:0] k, input logic [79:0] v);
    ser_q.push_back(1'b0);
    for (int i = 0; i < 80; i++) ser_q.push_back(v[i]);
    for (int i = 0; i < 80; i++) ser_q.push_back(k[i]);
    run_q.push_back(161);
  endtask

  task automatic do_load(input logic [79:0] k, input logic [79:0] v);
    @(negedge clk_i);
    key_i = k; iv_i = v; load_i = 1'b1;
    push_load(k, v);
    #1 chk("load_ready", load_ready_o, 1);
    @(posedge clk_i);
    #1 load_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] expw, input logic rdy);
    int n;
    @(negedge clk_i);
    din_i = w; din_valid_i = 1'b1; dout_ready_i = rdy;
    ser_q.push_back(w[0]);
    ser_q.push_back(w[0]);
    for (int i = 0; i < 32; i++) ser_q.push_back(w[i]);
    run_q.push_back(34);
    #1;
    n = 0;
    while (!din_ready_o && n < 200) begin
      @(negedge clk_i); #1; n++;
    end
    chk("din_accept", din_ready_o, 1);
    dexp_q.push_back(expw);
    dcyc_q.push_back(cyc + 35);
    @(posedge clk_i);
    #1 din_valid_i = 1'b0;
  endtask

  task automatic wait_keyed(input string name);
    int n;
    n = 0;
    while (!keyed_o && n < 400) begin
      @(negedge clk_i); n++;
    end
    chk(name, keyed_o, 1);
  endtask

  task automatic wait_init_low();
    int n;
    n = 0;
    @(negedge clk_i);
    while (core_init_o && n < 400) begin
      @(negedge clk_i); n++;
    end
    chk("init_drop", core_init_o, 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (dexp_q.size() != 0 && n < 200) begin
      @(negedge clk_i); n++;
    end
    chk("dout_drain", dexp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b0; key_i = '0; iv_i = '0; load_i = 1'b0; end_i = 1'b0;
    din_i = '0; din_valid_i = 1'b0; dout_ready_i = 1'b1; core_busy_i = 1'b0;
    #2 rst_i = 1'b1;
    #2;
    chk("rst_load_ready", load_ready_o, 1);
    chk("rst_din_ready", din_ready_o, 0);
    chk("rst_dout_valid", dout_valid_o, 0);
    chk("rst_dout", dout_o, 0);
    chk("rst_keyed", keyed_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_core_init", core_init_o, 0);
    chk("rst_core_dat", core_dat_o, 0);
    chk("rst_core_end", core_end_o, 0);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;

    // All-zero key/IV; busy released 1152 cycles after init drops.
    core_busy_i = 1'b1;
    do_load(80'h0, 80'h0);
    wait_init_low();
    repeat (1152) @(negedge clk_i);
    chk("keyed_while_busy", keyed_o, 0);
    core_busy_i = 1'b0;
    @(negedge clk_i);
    chk("keyed_after_busy", keyed_o, 1);
    chk("ready_load_ready", load_ready_o, 1);
    chk("ready_init_low", core_init_o, 0);

    // Patterned key/IV streamed bit for bit.
    do_load(80'h0123456789ABCDEF0123, 80'hFEDCBA9876543210FEDC);
    wait_keyed("keyed_pattern");

    // Single word through the inverting core stand-in.
    send_word(32'hA5A5_0001, 32'h5A5A_FFFE, 1'b1);
    wait_drain();

    // Stalled output, then a back-to-back accept on the release cycle.
    send_word(32'h1234_5678, 32'hEDCB_A987, 1'b0);
    begin
      int n;
      n = 0;
      while (!dout_valid_o && n < 100) begin
        @(negedge clk_i); n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      din_i = 32'h0000_FFFF; din_valid_i = 1'b1;
      #1;
      chk("stall_din_ready", din_ready_o, 0);
      chk("stall_dout_valid", dout_valid_o, 1);
      chk("stall_dout", dout_o, 32'hEDCB_A987);
    end
    send_word(32'h0000_FFFF, 32'hFFFF_0000, 1'b1);
    chk("b2b_start", core_init_o, 1);
    chk("b2b_dout_cleared", dout_valid_o, 0);
    wait_drain();

    // Busy stuck high: timeout after 2048 WAIT_BUSY cycles.
    core_busy_i = 1'b1;
    do_load(80'h0000_0000_0000_0000_0001, 80'h8000_0000_0000_0000_0002);
    wait_init_low();
    repeat (2047) @(negedge clk_i);
    chk("err_before_timeout", err_o, 0);
    @(negedge clk_i);
    chk("err_timeout", err_o, 1);
    chk("timeout_idle", load_ready_o, 1);
    chk("timeout_unkeyed", keyed_o, 0);
    core_busy_i = 1'b0;
    do_load(80'h0F0F_0F0F_0F0F_0F0F_0F0F, 80'h3333_5555_3333_5555_3333);
    chk("err_cleared", err_o, 0);
    wait_keyed("keyed_after_err");

    // Reset during SHIFT bit 17: no output word, immediate reset values.
    send_word(32'hDEAD_BEEF, 32'h2152_4110, 1'b1);
    repeat (19) @(posedge clk_i);
    #2 rst_i = 1'b1;
    ser_q.delete(); run_q.delete(); dexp_q.delete(); dcyc_q.delete();
    #1;
    chk("midrst_core_init", core_init_o, 0);
    chk("midrst_core_dat", core_dat_o, 0);
    chk("midrst_dout_valid", dout_valid_o, 0);
    chk("midrst_load_ready", load_ready_o, 1);
    chk("midrst_keyed", keyed_o, 0);
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    chk("postrst_dout_valid", dout_valid_o, 0);

    // load_i and end_i together in READY: load wins.
    do_load(80'hAAAA_0000_FFFF_1234_5678, 80'h1357_9BDF_0246_8ACE_0001);
    wait_keyed("keyed_before_tie");
    @(negedge clk_i);
    key_i = 80'hC3C3_C3C3_C3C3_C3C3_C3C3; iv_i = 80'h0000_0000_0000_0000_8001;
    load_i = 1'b1; end_i = 1'b1;
    push_load(key_i, iv_i);
    #1;
    chk("tie_core_end", core_end_o, 0);
    chk("tie_din_ready", din_ready_o, 0);
    @(posedge clk_i);
    #1 load_i = 1'b0; end_i = 1'b0;
    chk("tie_wake_init", core_init_o, 1);
    chk("tie_unkeyed", keyed_o, 0);
    chk("tie_core_end_after", core_end_o, 0);
    wait_keyed("keyed_after_tie");

    // end_i alone ends the session.
    @(negedge clk_i);
    end_i = 1'b1;
    #1 chk("end_pulse", core_end_o, 1);
    @(posedge clk_i);
    #1 end_i = 1'b0;
    chk("end_idle", load_ready_o, 1);
    chk("end_unkeyed", keyed_o, 0);
    chk("end_pulse_gone", core_end_o, 0);

    repeat (3) @(negedge clk_i);
    chk("serial_queue_empty", ser_q.size(), 0);
    chk("run_queue_empty", run_q.size(), 0);
    chk("dout_queue_empty", dexp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
